// File: rtl/adsd_pkg.sv
// adsd_pkg: state encoding, default width and timing formulas shared by the LED shifter and its bench
package adsd_pkg;
    localparam int DEF_DATA_W = 8;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t LATCH = 2'd2;
    function automatic int sclk_period(input int clk_div);
        return 2 * clk_div;
    endfunction
    function automatic int frame_cycles(input int data_w, input int clk_div);
        return (2 * data_w + 1) * clk_div;
    endfunction
endpackage

// File: rtl/adsd_led_shifter_if.sv
// adsd_led_shifter_if: core-side write port of the serial LED shifter
interface adsd_led_shifter_if import adsd_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              busy;
    logic              ovf;
    modport master(output wr_en, wr_data, input full, busy, ovf);
    modport slave(input wr_en, wr_data, output full, busy, ovf);
endinterface

// File: rtl/adsd_sync_fifo.sv
// adsd_sync_fifo: single-clock FIFO with registered occupancy count; pointers wrap at DEPTH
module adsd_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/adsd_led_shifter.sv
// adsd_led_shifter: buffers core byte writes and shifts them MSB first into a 74HC595-style chain,
// then pulses the storage latch and records the latched word in led_shadow
module adsd_led_shifter import adsd_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                clk,
    input  logic                rst,
    adsd_led_shifter_if.slave   bus,
    output logic                sclk,
    output logic                sdata,
    output logic                latch,
    output logic [DATA_W-1:0]   led_shadow
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = DATA_W > 2 ? $clog2(DATA_W) : 1;
    state_t                          state;
    logic [DATA_W-1:0]               fifo_q, sreg;
    logic [DIV_W-1:0]                div;
    logic [BIT_W-1:0]                bitcnt;
    logic [$clog2(FIFO_DEPTH+1)-1:0] count;
    logic                            empty, pop, div_tc, ovf;
    assign pop      = state == IDLE && !empty;
    assign div_tc   = div == DIV_W'(CLK_DIV - 1);
    assign bus.busy = count != '0 || state != IDLE;
    assign bus.ovf  = ovf;
    adsd_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(bus.wr_en), .pop(pop), .din(bus.wr_data),
        .dout(fifo_q), .count(count), .full(bus.full), .empty(empty)
    );
    // sreg rotates rather than shifts so it holds the original word again after DATA_W falling edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            div        <= '0;
            bitcnt     <= '0;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
            latch      <= 1'b0;
            led_shadow <= '0;
            ovf        <= 1'b0;
        end else begin
            if (bus.wr_en && bus.full) ovf <= 1'b1;
            case (state)
                IDLE: if (!empty) begin
                    sreg   <= fifo_q;
                    sdata  <= fifo_q[DATA_W-1];
                    sclk   <= 1'b0;
                    div    <= '0;
                    bitcnt <= '0;
                    state  <= SHIFT;
                end
                SHIFT: if (div_tc) begin
                    div  <= '0;
                    sclk <= !sclk;
                    if (sclk) begin
                        sreg <= {sreg[DATA_W-2:0], sreg[DATA_W-1]};
                        if (bitcnt == BIT_W'(DATA_W - 1)) begin
                            latch <= 1'b1;
                            state <= LATCH;
                        end else begin
                            sdata  <= sreg[DATA_W-2];
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end else div <= div + 1'b1;
                LATCH: if (div_tc) begin
                    div        <= '0;
                    latch      <= 1'b0;
                    led_shadow <= sreg;
                    state      <= IDLE;
                end else div <= div + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
